spi1_wb_controller: RTL and testbench
=====================================

# spi1_wb_controller

SPI-peripheral to Wishbone bus-master bridge. The host MCU uses it to read and write the 20-bit system address space of the FPGA. Each SPI command byte stream decodes into at most one Wishbone classic-pipelined cycle on `wb_clock_i`. `spi_stall_o` tells the host to pause clocking until that cycle has been acknowledged.

## Interface
Parameters (from `common_pkg`, not overridable):
- `WB_ADDR_WIDTH`, 20: Wishbone address width.
- `DATA_WIDTH`, 8: Wishbone data width.

Ports:
- `wb_clock_i`  in  1  system clock. Reset is asynchronous and active-low.
- `wb_reset_ni`  in  1  asynchronous active-low reset.
- `wb_addr_o`  out  20  cycle address; reset 0.
- `wb_data_i`  in  8  read data, valid with `wb_ack_i`.
- `wb_data_o`  out  8  write data; reset 0.
- `wb_we_o`  out  1  1 = write; reset 0.
- `wb_cycle_o`  out  1  cycle/strobe; reset 0.
- `wb_stall_i`  in  1  slave not ready; request is held.
- `wb_ack_i`  in  1  single-clock completion.
- `spi_sck_i`  in  1  SPI clock, mode 0, asynchronous.
- `spi_cs_ni`  in  1  chip select, active-low, asynchronous.
- `spi_sd_i`  in  1  PICO, MSB first.
- `spi_sd_o`  out  1  POCI, MSB first; reset 0.
- `spi_stall_o`  out  1  host must wait while 1; reset 0.

## Operation
- `spi_sck_i`, `spi_cs_ni` and `spi_sd_i` each pass through a 2-FF synchronizer into `wb_clock_i`, followed by a registered edge detect.
- Rising SCK edge: shift `spi_sd_i` into the RX register.
- Falling SCK edge: shift the next TX bit onto `spi_sd_o`.
- After 8 rising edges a byte is complete and the byte counter advances.
- The first byte of a transfer is the command byte: bits [7:5] = command, bits [3:0] = A[19:16].
- Command `3'b100` WRITE_AT: followed by A[15:8], A[7:0], data. The cycle launches after the data byte.
- Command `3'b101` WRITE_NEXT: followed by data. Address = pointer+1; the cycle launches after the data byte.
- Command `3'b110` READ_AT: followed by A[15:8], A[7:0]. The cycle launches after A[7:0].
- Command `3'b111` READ_NEXT: no further bytes. Address = pointer+1; the cycle launches after the command byte.
- Other commands: ignored; no cycle is issued.
- Address pointer: after every launched cycle (read or write), pointer = cycle address. Increment wraps modulo 2^20, so 0xFFFFF+1 = 0x00000.
- Cycle launch:
  - In one clock, drive addr, we and data, set `wb_cycle_o`=1 and `spi_stall_o`=1.
  - Hold addr, we and data stable while `wb_stall_i`=1.
- Completion:
  - On the clock edge where `wb_ack_i` is sampled 1, clear `wb_cycle_o` and `spi_stall_o`.
  - On a read, load `wb_data_i` into the TX register; it is shifted out on the next byte the host clocks.
- Bytes beyond the command's length are ignored, but TX keeps shifting.
- CS assert (falling `spi_cs_ni`): reset the byte and bit counters.
- CS deassert (rising `spi_cs_ni`):
  - Abort any in-progress cycle: `wb_cycle_o`=0 and `spi_stall_o`=0.
  - Discard the partial command.
  - Keep the address pointer.
- Reset clears the counters, the pointer, the TX and RX registers, and all outputs.

## Timing
- SCK high and low phases must each be ≥ 3 `wb_clock_i` periods.
- CS edge to effect: 3 clocks (2 sync + 1 edge detect). After the 3rd edge, `spi_stall_o`=0 on deassert and `wb_cycle_o`=0 on either CS edge.
- Launch latency: `wb_cycle_o` rises ≤ 4 clocks after the final rising SCK edge of the triggering byte.
- Ack: `wb_cycle_o` is still 1 at the ack-sampling edge and is 0 from that edge onward. `wb_ack_i` for a cycle that has already ended is ignored.
- `spi_stall_o` falls in the same clock as `wb_cycle_o`.
- Simultaneous CS deassert and ack: the abort wins; read data is not loaded.

## Structure
- `common_pkg`: `WB_ADDR_WIDTH`, `DATA_WIDTH`, `SYS_CLOCK_MHZ`, and a command-code enum.
- Sub-module `sync2`: 2-FF synchronizer with rising/falling edge outputs, instantiated for SCK, CS and SD.
- Main FSM states:
  - IDLE → CMD
  - CMD → ADDR_HI → ADDR_LO → DATA → BUS
  - WRITE_NEXT: CMD → DATA → BUS
  - READ_AT: CMD → ADDR_HI → ADDR_LO → BUS
  - READ_NEXT: CMD → BUS
  - BUS → CMD on ack
  - Any state → IDLE on CS deassert

## Test plan
- WRITE_AT 0x00000, data 0x00: one cycle with addr=0x00000, we=1, wr_data=0x00. The ack returns `wb_cycle_o` to 0 on the next edge and drops `spi_stall_o`.
- Five READ_NEXT after that write: cycles at 0x00001 to 0x00005 with we=0. With `wb_data_i`=0x01, the following SPI byte returns 0x01 on POCI.
- WRITE_AT 0xFFFFF, data 0x5A, then READ_NEXT: write at 0xFFFFF, then read at 0x00000.
- `wb_stall_i` held 1 for 3 clocks: addr, we and data stay stable and `spi_stall_o` stays 1 until ack.
- CS deassert while a cycle awaits ack: 3 clocks later, `wb_cycle_o`=0 and `spi_stall_o`=0. A later ack is ignored.
- Reset asserted mid-byte: all outputs are 0 immediately. The next READ_NEXT targets 0x00001.

Source files
------------

// File: rtl/common_pkg.sv
// common_pkg: shared widths, clock rate and encodings for the SPI to
// Wishbone bridge.
//   WB_ADDR_WIDTH : Wishbone address width (20-bit system address space)
//   DATA_WIDTH    : Wishbone data width
//   SYS_CLOCK_MHZ : nominal wb_clock_i frequency
//   cmd_e         : command codes carried in bits [7:5] of the first byte
//   state_e       : main bridge FSM states
package common_pkg;

   localparam int WB_ADDR_WIDTH = 20;
   localparam int DATA_WIDTH    = 8;
   localparam int SYS_CLOCK_MHZ = 50;

   typedef enum logic [2:0] {
      CMD_WRITE_AT   = 3'b100,
      CMD_WRITE_NEXT = 3'b101,
      CMD_READ_AT    = 3'b110,
      CMD_READ_NEXT  = 3'b111
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR_HI = 3'd2,
      ST_ADDR_LO = 3'd3,
      ST_DATA    = 3'd4,
      ST_BUS     = 3'd5
   } state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input, followed by one
// more flop so that edges can be detected on the synchronized level.
//   clk_i     : destination clock
//   rst_ni    : asynchronous active-low reset
//   d_i       : asynchronous input
//   q_o       : synchronized level
//   rise_o    : one-clock pulse on a synchronized 0->1 transition
//   fall_o    : one-clock pulse on a synchronized 1->0 transition
// RESET_VAL is the idle level of the input so no false edge appears when
// reset is released.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi1_wb_controller.sv
// spi1_wb_controller: SPI mode-0 peripheral that turns short command byte
// streams from a host MCU into single Wishbone classic-pipelined cycles.
//   wb_clock_i / wb_reset_ni : system clock, asynchronous active-low reset
//   wb_addr_o/data_o/we_o    : cycle address, write data, write enable
//   wb_cycle_o               : combined cycle/strobe, held until ack
//   wb_data_i, wb_ack_i      : read data and single-clock completion
//   wb_stall_i               : slave not ready (request is simply held)
//   spi_sck_i/cs_ni/sd_i     : asynchronous SPI inputs (mode 0, MSB first)
//   spi_sd_o                 : POCI
//   spi_stall_o              : host must stop clocking while 1
// Handshake: a cycle is presented with wb_cycle_o=1 and addr/we/data stable;
// it ends on the clock edge where wb_ack_i is sampled 1. An ack seen while
// no cycle is open is ignored.
module spi1_wb_controller
   import common_pkg::*;
(
   input  logic                     wb_clock_i,
   input  logic                     wb_reset_ni,
   output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
   input  logic [DATA_WIDTH-1:0]    wb_data_i,
   output logic [DATA_WIDTH-1:0]    wb_data_o,
   output logic                     wb_we_o,
   output logic                     wb_cycle_o,
   input  logic                     wb_stall_i,
   input  logic                     wb_ack_i,
   input  logic                     spi_sck_i,
   input  logic                     spi_cs_ni,
   input  logic                     spi_sd_i,
   output logic                     spi_sd_o,
   output logic                     spi_stall_o
);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic sd_lvl, sd_rise, sd_fall;

   sync2 #(.RESET_VAL(1'b0)) u_sync_sck (
      .clk_i(wb_clock_i), .rst_ni(wb_reset_ni), .d_i(spi_sck_i),
      .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));

   sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
      .clk_i(wb_clock_i), .rst_ni(wb_reset_ni), .d_i(spi_cs_ni),
      .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

   sync2 #(.RESET_VAL(1'b0)) u_sync_sd (
      .clk_i(wb_clock_i), .rst_ni(wb_reset_ni), .d_i(spi_sd_i),
      .q_o(sd_lvl), .rise_o(sd_rise), .fall_o(sd_fall));

   // The request is held until ack whether or not the slave stalls, so the
   // stall input needs no logic of its own.
   logic unused_ok;
   assign unused_ok = ^{cs_lvl, sd_rise, sd_fall, wb_stall_i};

   state_e                   state_q;
   logic [2:0]               cmd_q;
   logic [3:0]               a_top_q;
   logic [7:0]               a_mid_q;
   logic [7:0]               a_lo_q;
   logic [WB_ADDR_WIDTH-1:0] addr_q;   // also the address pointer
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic                     we_q;
   logic                     cyc_q;
   logic                     stall_q;
   logic [7:0]               rx_q;
   logic [7:0]               tx_q;
   logic                     sd_o_q;
   logic [2:0]               bit_cnt_q;
   logic [1:0]               byte_cnt_q;  // saturates; only "first byte" matters

   logic [7:0]               rx_byte_d;
   logic                     byte_done;
   logic                     launch_d;
   logic                     launch_we_d;
   logic [WB_ADDR_WIDTH-1:0] launch_addr_d;
   logic [DATA_WIDTH-1:0]    launch_data_d;

   assign rx_byte_d = {rx_q[6:0], sd_lvl};
   assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

   // Decide whether the byte completing this clock launches a bus cycle.
   always_comb begin
      launch_d      = 1'b0;
      launch_we_d   = 1'b0;
      launch_addr_d = addr_q + WB_ADDR_WIDTH'(1);
      launch_data_d = wdata_q;
      case (state_q)
         ST_CMD: begin
            if (byte_cnt_q == 2'd0 && rx_byte_d[7:5] == CMD_READ_NEXT)
               launch_d = byte_done;
         end
         ST_ADDR_LO: begin
            if (cmd_q == CMD_READ_AT) begin
               launch_d      = byte_done;
               launch_addr_d = {a_top_q, a_mid_q, rx_byte_d};
            end
         end
         ST_DATA: begin
            launch_d      = byte_done;
            launch_we_d   = 1'b1;
            launch_data_d = rx_byte_d;
            if (cmd_q == CMD_WRITE_AT)
               launch_addr_d = {a_top_q, a_mid_q, a_lo_q};
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
      if (!wb_reset_ni) begin
         state_q    <= ST_IDLE;
         cmd_q      <= 3'd0;
         a_top_q    <= 4'd0;
         a_mid_q    <= 8'd0;
         a_lo_q     <= 8'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         stall_q    <= 1'b0;
         rx_q       <= 8'd0;
         tx_q       <= 8'd0;
         sd_o_q     <= 1'b0;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 2'd0;
      end else begin
         if (sck_rise) begin
            rx_q      <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && byte_cnt_q != 2'd3)
               byte_cnt_q <= byte_cnt_q + 2'd1;
         end
         if (sck_fall) begin
            sd_o_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
         end

         if (cs_rise) begin
            // Deassert aborts everything but keeps the pointer (addr_q).
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stall_q <= 1'b0;
         end else if (cs_fall) begin
            state_q    <= ST_CMD;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            cyc_q      <= 1'b0;
            stall_q    <= 1'b0;
         end else if (launch_d) begin
            addr_q  <= launch_addr_d;
            we_q    <= launch_we_d;
            wdata_q <= launch_data_d;
            cyc_q   <= 1'b1;
            stall_q <= 1'b1;
            state_q <= ST_BUS;
         end else begin
            case (state_q)
               ST_CMD: begin
                  // Only the first byte of a transfer is a command; later
                  // bytes (after a completed cycle or a bad code) are ignored.
                  if (byte_done && byte_cnt_q == 2'd0) begin
                     cmd_q   <= rx_byte_d[7:5];
                     a_top_q <= rx_byte_d[3:0];
                     case (rx_byte_d[7:5])
                        CMD_WRITE_AT, CMD_READ_AT: state_q <= ST_ADDR_HI;
                        CMD_WRITE_NEXT:            state_q <= ST_DATA;
                        default: ;
                     endcase
                  end
               end
               ST_ADDR_HI: begin
                  if (byte_done) begin
                     a_mid_q <= rx_byte_d;
                     state_q <= ST_ADDR_LO;
                  end
               end
               ST_ADDR_LO: begin
                  if (byte_done) begin
                     a_lo_q  <= rx_byte_d;
                     state_q <= ST_DATA;
                  end
               end
               ST_BUS: begin
                  if (wb_ack_i) begin
                     cyc_q   <= 1'b0;
                     stall_q <= 1'b0;
                     state_q <= ST_CMD;
                     if (!we_q) begin
                        // If SCK is still high the last falling edge of the
                        // byte is yet to come and will present the MSB;
                        // otherwise present the MSB now.
                        if (sck_lvl) begin
                           tx_q <= wb_data_i;
                        end else begin
                           sd_o_q <= wb_data_i[7];
                           tx_q   <= {wb_data_i[6:0], 1'b0};
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign wb_addr_o   = addr_q;
   assign wb_data_o   = wdata_q;
   assign wb_we_o     = we_q;
   assign wb_cycle_o  = cyc_q;
   assign spi_stall_o = stall_q;
   assign spi_sd_o    = sd_o_q;

endmodule

// File: tb/tb_spi1_wb_controller.sv
// Bench for spi1_wb_controller: an SPI host driver, a Wishbone slave
// responder and a frame-level reference model feeding an expected queue.
module tb_spi1_wb_controller;

   localparam int HALF = 5;    // SCK half period in wb clocks
   localparam int TMO  = 400;  // bound on any wait for the DUT

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] wb_addr_o;
   logic [7:0]  wb_data_i;
   logic [7:0]  wb_data_o;
   logic        wb_we_o;
   logic        wb_cycle_o;
   logic        wb_stall_i;
   logic        wb_ack_i;
   logic        resp_ack;
   logic        stray_ack;
   logic        spi_sck_i = 1'b0;
   logic        spi_cs_ni = 1'b1;
   logic        spi_sd_i = 1'b0;
   logic        spi_sd_o;
   logic        spi_stall_o;

   assign wb_ack_i = resp_ack | stray_ack;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   spi1_wb_controller dut (
      .wb_clock_i(clk), .wb_reset_ni(rst_n),
      .wb_addr_o(wb_addr_o), .wb_data_i(wb_data_i), .wb_data_o(wb_data_o),
      .wb_we_o(wb_we_o), .wb_cycle_o(wb_cycle_o), .wb_stall_i(wb_stall_i),
      .wb_ack_i(wb_ack_i), .spi_sck_i(spi_sck_i), .spi_cs_ni(spi_cs_ni),
      .spi_sd_i(spi_sd_i), .spi_sd_o(spi_sd_o), .spi_stall_o(spi_stall_o));

   // ---------------- scoreboard state ----------------
   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [28:0] exp_q[$];      // {we, addr[19:0], data[7:0]}
   logic [7:0]  frame_q[$];
   int          model_ptr = 0;
   logic [7:0]  last_rd = 8'h00;
   bit          resp_en = 1'b1;
   int          force_stall = -1;
   bit          rd_fixed_en = 1'b0;
   logic [7:0]  rd_fixed = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame-level model: decode the bytes of one CS frame, queue the cycle it
   // must produce and move the pointer. trig = index of the launching byte.
   task automatic model_frame(output int trig, output bit is_rd);
      int n;
      int a;
      logic [2:0] c;
      n = frame_q.size();
      c = frame_q[0][7:5];
      trig = -1;
      is_rd = 1'b0;
      a = 0;
      case (c)
         3'b100: if (n >= 4) begin
            a = int'({frame_q[0][3:0], frame_q[1], frame_q[2]});
            exp_q.push_back({1'b1, 20'(a), frame_q[3]});
            trig = 3;
         end
         3'b101: if (n >= 2) begin
            a = (model_ptr + 1) % 1048576;
            exp_q.push_back({1'b1, 20'(a), frame_q[1]});
            trig = 1;
         end
         3'b110: if (n >= 3) begin
            a = int'({frame_q[0][3:0], frame_q[1], frame_q[2]});
            exp_q.push_back({1'b0, 20'(a), 8'h00});
            trig = 2;
            is_rd = 1'b1;
         end
         3'b111: begin
            a = (model_ptr + 1) % 1048576;
            exp_q.push_back({1'b0, 20'(a), 8'h00});
            trig = 0;
            is_rd = 1'b1;
         end
         default: ;
      endcase
      if (trig >= 0) model_ptr = a;
   endtask

   task automatic check_cycle(output logic [28:0] e);
      check_eq("cycle_expected", (exp_q.size() > 0), 1);
      e = '0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("cyc_addr", wb_addr_o, e[27:8]);
         check_eq("cyc_we", wb_we_o, e[28]);
         if (e[28]) check_eq("cyc_wdata", wb_data_o, e[7:0]);
      end
   endtask

   // ---------------- Wishbone slave responder ----------------
   initial begin : wb_responder
      logic [28:0] e;
      int n;
      resp_ack = 1'b0;
      wb_stall_i = 1'b0;
      wb_data_i = 8'h00;
      forever begin
         @(negedge clk);
         if (resp_en && wb_cycle_o === 1'b1) begin
            check_cycle(e);
            check_eq("stall_on_launch", spi_stall_o, 1);
            n = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
            force_stall = -1;
            wb_stall_i = (n > 0);
            for (int i = 0; i < n; i++) begin
               @(negedge clk);
               check_eq("hold_addr", wb_addr_o, e[27:8]);
               check_eq("hold_we", wb_we_o, e[28]);
               if (e[28]) check_eq("hold_data", wb_data_o, e[7:0]);
               check_eq("hold_spi_stall", spi_stall_o, 1);
               if (i == n - 1) wb_stall_i = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check_eq("cyc_before_ack", wb_cycle_o, 1);
            resp_ack = 1'b1;
            wb_data_i = rd_fixed_en ? rd_fixed : 8'($urandom);
            if (!e[28]) last_rd = wb_data_i;
            @(negedge clk);
            resp_ack = 1'b0;
            check_eq("cyc_after_ack", wb_cycle_o, 0);
            check_eq("spi_stall_after_ack", spi_stall_o, 0);
         end
      end
   end

   // ---------------- SPI host driver tasks ----------------
   task automatic wait_no_stall();
      int t = 0;
      while (spi_stall_o === 1'b1 && t < TMO) begin
         @(posedge clk); #3;
         t++;
      end
      if (t == TMO) check_eq("stall_timeout", spi_stall_o, 0);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         wait_no_stall();
         spi_sd_i = tx[i];
         repeat (HALF) @(posedge clk);
         #3;
         rx[i] = spi_sd_o;
         spi_sck_i = 1'b1;
         repeat (HALF) @(posedge clk);
         #3;
         spi_sck_i = 1'b0;
      end
   endtask

   task automatic cs_assert();
      spi_cs_ni = 1'b0;
      repeat (5) @(posedge clk);
      #3;
   endtask

   task automatic cs_deassert();
      wait_no_stall();
      repeat (4) @(posedge clk);
      #3;
      spi_cs_ni = 1'b1;
      repeat (6) @(posedge clk);
      #3;
   endtask

   task automatic run_frame();
      int trig;
      bit is_rd;
      logic [7:0] rx;
      model_frame(trig, is_rd);
      cs_assert();
      for (int i = 0; i < frame_q.size(); i++) begin
         spi_byte(frame_q[i], rx);
         if (is_rd && i == trig + 1) check_eq("poci_read_data", rx, last_rd);
      end
      cs_deassert();
      check_eq("exp_drained", exp_q.size(), 0);
   endtask

   task automatic gen_frame();
      logic [2:0]  c;
      logic [19:0] a;
      int extra;
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) c[2] = 1'b1;
      a = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
      frame_q.delete();
      frame_q.push_back({c, 1'($urandom), a[19:16]});
      if (c == 3'b100 || c == 3'b110) begin
         frame_q.push_back(a[15:8]);
         frame_q.push_back(a[7:0]);
      end
      if (c == 3'b100 || c == 3'b101) frame_q.push_back(8'($urandom));
      if (frame_q.size() > 1 && $urandom_range(0, 7) == 0) void'(frame_q.pop_back());
      extra = $urandom_range(0, 2);
      if (c[2] && c[1]) extra++;
      repeat (extra) frame_q.push_back(8'($urandom));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #3ms;
      err_cnt++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main_seq
      logic [28:0] e;
      logic [7:0]  rx;
      int t;
      int trig;
      bit is_rd;
      stray_ack = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_addr", wb_addr_o, 0);
      check_eq("rst_data", wb_data_o, 0);
      check_eq("rst_we", wb_we_o, 0);
      check_eq("rst_cyc", wb_cycle_o, 0);
      check_eq("rst_sd_o", spi_sd_o, 0);
      check_eq("rst_stall", spi_stall_o, 0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #3;

      // WRITE_AT 0x00000 data 0x00
      frame_q = '{8'h80, 8'h00, 8'h00, 8'h00};
      run_frame();

      // five READ_NEXT returning 0x01
      rd_fixed_en = 1'b1;
      rd_fixed = 8'h01;
      for (int k = 0; k < 5; k++) begin
         frame_q = '{8'hE0, 8'h00};
         run_frame();
      end
      rd_fixed_en = 1'b0;

      // wrap: WRITE_AT 0xFFFFF 0x5A then READ_NEXT
      frame_q = '{8'h8F, 8'hFF, 8'hFF, 8'h5A};
      run_frame();
      frame_q = '{8'hE0, 8'h00};
      run_frame();

      // slave stall held for three clocks on a READ_AT
      force_stall = 3;
      frame_q = '{8'hC0, 8'hAB, 8'hCD, 8'h00};
      run_frame();

      // ignored command code
      frame_q = '{8'h2F, 8'h11, 8'h22, 8'h33};
      run_frame();

      // CS deassert while a cycle awaits ack
      resp_en = 1'b0;
      frame_q = '{8'h81, 8'h23, 8'h45, 8'hC3};
      model_frame(trig, is_rd);
      cs_assert();
      for (int i = 0; i < frame_q.size(); i++) spi_byte(frame_q[i], rx);
      t = 0;
      while (wb_cycle_o !== 1'b1 && t < TMO) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("abort_cyc_launched", wb_cycle_o, 1);
      check_cycle(e);
      @(posedge clk);
      #1;
      spi_cs_ni = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("abort_cyc_before_3rd", wb_cycle_o, 1);
      @(posedge clk);
      #1;
      check_eq("abort_cyc_after_3rd", wb_cycle_o, 0);
      check_eq("abort_stall_after_3rd", spi_stall_o, 0);
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("stray_ack_cyc", wb_cycle_o, 0);
      check_eq("stray_ack_stall", spi_stall_o, 0);
      resp_en = 1'b1;
      repeat (4) @(posedge clk);
      #3;

      // pointer survives the abort
      frame_q = '{8'hA0, 8'h77};
      run_frame();

      // reset in the middle of a byte
      spi_cs_ni = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      for (int i = 0; i < 4; i++) begin
         spi_sd_i = 1'b1;
         repeat (HALF) @(posedge clk);
         #3;
         spi_sck_i = 1'b1;
         repeat (HALF) @(posedge clk);
         #3;
         spi_sck_i = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_addr", wb_addr_o, 0);
      check_eq("midrst_data", wb_data_o, 0);
      check_eq("midrst_we", wb_we_o, 0);
      check_eq("midrst_cyc", wb_cycle_o, 0);
      check_eq("midrst_sd_o", spi_sd_o, 0);
      check_eq("midrst_stall", spi_stall_o, 0);
      spi_cs_ni = 1'b1;
      model_ptr = 0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      frame_q = '{8'hE0, 8'h00};
      run_frame();

      // randomized frames
      for (int k = 0; k < 40; k++) begin
         gen_frame();
         run_frame();
      end

      check_eq("final_exp_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
